dmem_arbiter: RTL and testbench

//  Shares the single-port data memory between the pipeline MEM stage and an external host port
//  (program/data loader, debug). CPU has default ownership. Host gets the memory in bounded bursts.
//  cpu_stall freezes PC and all pipeline registers while the host owns the memory.

---
 rtl/dmem_arbiter.sv | 172 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the single-port data memory between the pipeline MEM stage and an
// external host port (program loader / debug). The CPU owns the memory by
// default. The host is granted the memory either when the CPU is idle or after
// it has waited MAX_WAIT cycles behind back-to-back CPU accesses. While the
// host owns the memory, any CPU access is frozen via cpu_stall. A CPU that is
// waiting gets the memory back after at most BURST_MAX host accesses.
//
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   cpu_rd/cpu_wr            MEM-stage load/store strobes
//   cpu_addr/cpu_wdata       MEM-stage address and store data
//   cpu_rdata                load data back to MEM/WB (valid when !cpu_stall)
//   cpu_stall                freeze PC and pipeline registers this cycle
//   host_req/host_we         host request (held until host_ack) and direction
//   host_addr/host_wdata     host address and write data
//   host_ack                 host access completes this cycle
//   host_rdata               host read data, valid with host_ack
//   dm_rd/dm_wr              data memory read/write enables (write on clk edge)
//   dm_addr/dm_wdata         data memory address and write data
//   dm_rdata                 data memory combinational read data
//   host_owner               high while the host owns the memory
//
// State table
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   CPU_OWN  | memory driven by cpu_* inputs; host waits (reset state)
//   HOST_OWN | memory driven by host_* inputs; CPU accesses are stalled
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_WAIT  = 8,
  parameter int BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic              dm_rd,
  output logic              dm_wr,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic              host_owner
);

  localparam logic [0:0] CPU_OWN  = 1'b0;
  localparam logic [0:0] HOST_OWN = 1'b1;

  localparam int WAIT_W  = (MAX_WAIT  > 1) ? $clog2(MAX_WAIT)  : 1;
  localparam int BURST_W = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;

  // Both counters run down to a terminal count of zero. waitLeft is the number
  // of further CPU-blocked cycles the host still tolerates; burstLeft is the
  // number of host acks still allowed before a waiting CPU takes back over.
  localparam logic [WAIT_W-1:0]  WAIT_LOAD  = WAIT_W'(MAX_WAIT - 1);
  localparam logic [BURST_W-1:0] BURST_LOAD = BURST_W'(BURST_MAX - 1);

  logic [0:0]         state;
  logic [0:0]         stateNext;
  logic [WAIT_W-1:0]  waitLeft;
  logic [WAIT_W-1:0]  waitLeftNext;
  logic [BURST_W-1:0] burstLeft;
  logic [BURST_W-1:0] burstLeftNext;

  logic cpuAcc;
  logic isHost;
  logic waitExpired;
  logic burstDone;

  assign cpuAcc      = cpu_rd | cpu_wr;
  assign isHost      = (state == HOST_OWN);
  assign waitExpired = (waitLeft == '0);
  assign burstDone   = (burstLeft == '0);

  // Next-state and counter logic.
  // The wait counter reloads whenever it is not actively counting, which covers
  // both "host_req low" and "entering HOST_OWN". The burst counter reloads on
  // every CPU_OWN cycle so it is fresh on entry to HOST_OWN; it stops at zero,
  // so once the burst budget is spent the next ack with a waiting CPU hands the
  // memory back even if some of the budget was used while the CPU was idle.
  always_comb begin
    stateNext     = state;
    waitLeftNext  = WAIT_LOAD;
    burstLeftNext = burstLeft;
    case (state)
      CPU_OWN: begin
        burstLeftNext = BURST_LOAD;
        if (host_req && (!cpuAcc || waitExpired)) begin
          stateNext = HOST_OWN;
        end else if (host_req) begin
          waitLeftNext = waitLeft - 1'b1;
        end
      end
      HOST_OWN: begin
        if (!host_req) begin
          stateNext = CPU_OWN;
        end else begin
          // host_req is the ack in this state; the access completes this cycle.
          if (cpuAcc && burstDone) begin
            stateNext = CPU_OWN;
          end
          if (!burstDone) begin
            burstLeftNext = burstLeft - 1'b1;
          end
        end
      end
      default: begin
        stateNext = CPU_OWN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= CPU_OWN;
      waitLeft  <= WAIT_LOAD;
      burstLeft <= BURST_LOAD;
    end else begin
      state     <= stateNext;
      waitLeft  <= waitLeftNext;
      burstLeft <= burstLeftNext;
    end
  end

  // Memory mux and handshake outputs. Strobes are forced low while rst is held
  // so a reset landing mid-burst can never complete a host write.
  always_comb begin
    dm_rd     = 1'b0;
    dm_wr     = 1'b0;
    dm_addr   = cpu_addr;
    dm_wdata  = cpu_wdata;
    host_ack  = 1'b0;
    cpu_stall = 1'b0;
    if (isHost) begin
      dm_addr   = host_addr;
      dm_wdata  = host_wdata;
      dm_rd     = host_req & ~host_we;
      dm_wr     = host_req & host_we;
      host_ack  = host_req;
      cpu_stall = cpuAcc;
    end else begin
      dm_rd = cpu_rd;
      dm_wr = cpu_wr;
    end
    if (rst) begin
      dm_rd     = 1'b0;
      dm_wr     = 1'b0;
      host_ack  = 1'b0;
      cpu_stall = 1'b0;
    end
  end

  // Read data is shared; each side only looks at it when its access completes.
  assign cpu_rdata  = dm_rdata;
  assign host_rdata = dm_rdata;
  assign host_owner = isHost & ~rst;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Self-checking bench for dmem_arbiter. Inputs change on the falling edge,
// outputs are sampled 1 time unit later, and the reference model advances on
// the rising edge. The model tracks who owns the memory, how long the host has
// waited and how many acks the current grant has given, plus a reference copy
// of memory contents. The bench also hosts the data memory the DUT drives.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int MAX_WAIT  = 8;
  localparam int BURST_MAX = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_rd = 1'b0;
  logic        cpu_wr = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        host_req = 1'b0;
  logic        host_we = 1'b0;
  logic [31:0] host_addr = '0;
  logic [31:0] host_wdata = '0;
  logic        host_ack;
  logic [31:0] host_rdata;
  logic        dm_rd;
  logic        dm_wr;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        host_owner;

  logic [31:0] devMem [0:255];
  logic [31:0] refMem [0:255];

  int compared = 0;
  int mismatched = 0;

  // reference model state
  bit mHost = 1'b0;
  int mWaited = 0;
  int mAcks = 0;

  // expectations for the current cycle
  bit          eOwner, eAck, eStall, eRd, eWr;
  logic [31:0] eAddr, eWdata;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT), .BURST_MAX(BURST_MAX)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata),
    .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .host_owner(host_owner)
  );

  assign dm_rdata = devMem[dm_addr[7:0]];

  always @(posedge clk) begin
    if (dm_wr) devMem[dm_addr[7:0]] = dm_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic setCpu(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    cpu_rd = rd; cpu_wr = wr; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic setHost(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
    host_req = req; host_we = we; host_addr = a; host_wdata = d;
  endtask

  // Sample outputs mid-cycle and compare them with the model's predictions.
  task automatic settle();
    #1;
    if (rst) begin
      mHost = 1'b0; mWaited = 0; mAcks = 0;
    end
    eOwner = !rst && mHost;
    eAck   = eOwner && host_req;
    eStall = eOwner && (cpu_rd || cpu_wr);
    eAddr  = mHost ? host_addr  : cpu_addr;
    eWdata = mHost ? host_wdata : cpu_wdata;
    if (rst) begin
      eRd = 1'b0; eWr = 1'b0;
    end else if (mHost) begin
      eRd = host_req && !host_we; eWr = host_req && host_we;
    end else begin
      eRd = cpu_rd; eWr = cpu_wr;
    end
    chk("host_owner", host_owner, eOwner);
    chk("host_ack", host_ack, eAck);
    chk("cpu_stall", cpu_stall, eStall);
    chk("dm_rd", dm_rd, eRd);
    chk("dm_wr", dm_wr, eWr);
    if (!rst) begin
      chk("dm_addr", dm_addr, eAddr);
      chk("dm_wdata", dm_wdata, eWdata);
    end
    if (eAck && !host_we) chk("host_rdata", host_rdata, refMem[host_addr[7:0]]);
    if (!rst && !mHost && cpu_rd) chk("cpu_rdata", cpu_rdata, refMem[cpu_addr[7:0]]);
  endtask

  // Advance the model across the rising edge, then return at the falling edge.
  task automatic advance();
    bit acc;
    @(posedge clk);
    acc = cpu_rd || cpu_wr;
    if (!rst) begin
      if (eWr) refMem[eAddr[7:0]] = eWdata;
      if (!mHost) begin
        if (host_req && (!acc || mWaited == MAX_WAIT - 1)) begin
          mHost = 1'b1; mWaited = 0; mAcks = 0;
        end else if (host_req) begin
          mWaited++;
        end else begin
          mWaited = 0;
        end
      end else if (!host_req) begin
        mHost = 1'b0;
      end else begin
        if (acc && mAcks >= BURST_MAX - 1) mHost = 1'b0;
        mAcks++;
      end
    end
    @(negedge clk);
  endtask

  task automatic cyc();
    settle();
    advance();
  endtask

  task automatic idle(input int n);
    setCpu(0, 0, '0, '0);
    setHost(0, 0, '0, '0);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    int grantAt, stalls, nAck, burstLen, burstAcks, cpuPct, hostPct;
    bit burstEnded, w;

    for (int i = 0; i < 256; i++) begin
      devMem[i] = 32'h1000_0000 + i;
      refMem[i] = 32'h1000_0000 + i;
    end
    devMem[8'h20] = 32'h5;
    refMem[8'h20] = 32'h5;

    // 1: reset blocks all strobes and handshakes
    setCpu(0, 1, 32'h30, 32'h77);
    setHost(1, 1, 32'h34, 32'h99);
    rst = 1'b1;
    @(negedge clk);
    settle();
    chk("t1_dm_wr", dm_wr, 0);
    chk("t1_ack", host_ack, 0);
    chk("t1_stall", cpu_stall, 0);
    chk("t1_owner", host_owner, 0);
    advance();
    rst = 1'b0;
    idle(2);

    // 2: idle CPU, host write then read back
    setHost(1, 1, 32'h10, 32'hDEADBEEF);
    settle();
    chk("t2_owner_c0", host_owner, 0);
    advance();
    settle();
    chk("t2_owner", host_owner, 1);
    chk("t2_ack", host_ack, 1);
    chk("t2_dm_wr", dm_wr, 1);
    chk("t2_dm_addr", dm_addr, 32'h10);
    advance();
    setHost(1, 0, 32'h10, '0);
    settle();
    chk("t2_rdata", host_rdata, 32'hDEADBEEF);
    advance();
    idle(2);

    // 4: host_req rises with a CPU load; CPU served first
    setCpu(1, 0, 32'h20, '0);
    setHost(1, 1, 32'h50, 32'h1234);
    settle();
    chk("t4_cpu_rdata", cpu_rdata, 32'h5);
    chk("t4_stall", cpu_stall, 0);
    chk("t4_owner", host_owner, 0);
    advance();
    setCpu(0, 0, '0, '0);
    cyc();
    settle();
    chk("t4_grant", host_owner, 1);
    chk("t4_ack", host_ack, 1);
    advance();
    idle(2);

    // 6: CPU store then host read of the same word
    setCpu(0, 1, 32'h40, 32'hA5);
    cyc();
    setCpu(0, 0, '0, '0);
    setHost(1, 0, 32'h40, '0);
    cyc();
    settle();
    chk("t6_ack", host_ack, 1);
    chk("t6_rdata", host_rdata, 32'hA5);
    advance();
    idle(2);

    // 3: back-to-back CPU loads, host held from cycle 0
    setCpu(1, 0, 32'h84, '0);
    setHost(1, 1, 32'hC0, 32'h3000_0000);
    grantAt = -1; stalls = 0; nAck = 0;
    for (int c = 0; c < 16; c++) begin
      settle();
      if (host_owner && grantAt < 0) grantAt = c;
      if (cpu_stall) stalls++;
      if (c == 12) begin
        chk("t3_resume", host_owner, 0);
        chk("t3_load", cpu_rdata, 32'h1000_0084);
      end
      advance();
      if (eAck) begin
        nAck++;
        if (nAck == 4) setHost(0, 0, '0, '0);
        else setHost(1, 1, 32'hC0 + 4 * nAck, 32'h3000_0000 + nAck);
      end
    end
    chk("t3_grant_cycle", grantAt, 8);
    chk("t3_stall_cycles", stalls, 4);
    idle(2);

    // 5: reset in the middle of a host burst
    setHost(1, 0, 32'h10, '0);
    cyc();
    setCpu(1, 0, 32'h84, '0);
    cyc();
    setHost(1, 0, 32'h14, '0);
    cyc();
    rst = 1'b1;
    settle();
    chk("t5_ack_rst", host_ack, 0);
    chk("t5_owner_rst", host_owner, 0);
    chk("t5_stall_rst", cpu_stall, 0);
    chk("t5_dm_rd_rst", dm_rd, 0);
    advance();
    rst = 1'b0;
    burstLen = 0; burstAcks = 0; burstEnded = 1'b0;
    for (int c = 0; c < 24; c++) begin
      settle();
      if (!burstEnded && host_owner) begin
        burstLen++;
        if (host_ack) burstAcks++;
      end
      if (burstLen > 0 && !host_owner) burstEnded = 1'b1;
      advance();
      if (eAck) setHost(1, 0, 32'h10 + 4 * (c % 8), '0);
    end
    chk("t5_burst_len", burstLen, 4);
    chk("t5_burst_acks", burstAcks, 4);
    idle(2);

    // randomized traffic with occasional resets
    cpuPct = 60; hostPct = 50;
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) begin
        cpuPct  = ($urandom_range(0, 1) != 0) ? 90 : 30;
        hostPct = ($urandom_range(0, 1) != 0) ? 90 : 40;
      end
      if (!eStall) begin
        if ($urandom_range(0, 99) < cpuPct) begin
          w = 1'($urandom_range(0, 1));
          setCpu(!w, w, 32'($urandom_range(0, 31) * 4), $urandom);
        end else begin
          setCpu(0, 0, '0, '0);
        end
      end
      if (!host_req || eAck) begin
        if ($urandom_range(0, 99) < hostPct)
          setHost(1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 31) * 4), $urandom);
        else
          setHost(0, 0, '0, '0);
      end
      rst = ($urandom_range(0, 299) == 0);
      cyc();
    end
    rst = 1'b0;
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
